// File: rtl/key_debounce_irq.sv
// Per-bit key conditioning: invert, 2-flop synchronise, debounce, and edge detect.
// Edges are held as sticky capture bits, and a masked OR drives a level irq.
module key_debounce_irq #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int ACTIVE_LOW      = 1,
  parameter int EDGE_MODE       = 2
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [WIDTH-1:0] keys_raw,
  output logic [WIDTH-1:0] keys_stable,
  output logic [WIDTH-1:0] edge_pulse,
  output logic [WIDTH-1:0] edge_capture,
  input  logic [WIDTH-1:0] capture_clear,
  input  logic [WIDTH-1:0] irq_mask,
  output logic             irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             CAP_RISE = (EDGE_MODE != 1);
  localparam logic             CAP_FALL = (EDGE_MODE != 0);

  logic [WIDTH-1:0] keys_in;
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] pulse_q, pulse_d;
  logic [WIDTH-1:0] capture_q, capture_d;
  logic [WIDTH-1:0] rise, fall;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  always_comb begin
    keys_in  = (ACTIVE_LOW != 0) ? ~keys_raw : keys_raw;
    sync1_d  = keys_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      // Counter only runs while the synchronised input disagrees with the
      // accepted level; any agreement (a bounce back) restarts it from zero.
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    rise      = stable_d & ~stable_q;
    fall      = ~stable_d & stable_q;
    pulse_d   = ({WIDTH{CAP_RISE}} & rise) | ({WIDTH{CAP_FALL}} & fall);
    // Set from the registered pulse wins over a coincident clear.
    capture_d = (capture_q & ~capture_clear) | pulse_q;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      pulse_q   <= '0;
      capture_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      pulse_q   <= pulse_d;
      capture_q <= capture_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign keys_stable  = stable_q;
  assign edge_pulse   = pulse_q;
  assign edge_capture = capture_q;
  assign irq          = |(capture_q & irq_mask);

endmodule

// File: tb/tb_key_debounce_irq.sv
// Bench for key_debounce_irq: directed scenarios then random key activity,
// all checked against a sliding-window reference model of the debouncer.
module tb_key_debounce_irq;
  localparam int D = 8;

  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic [3:0] keys_raw;
  logic [3:0] keys_stable, edge_pulse, edge_capture;
  logic [3:0] capture_clear, irq_mask;
  logic       irq;

  int total = 0;
  int bad   = 0;

  logic [3:0] pipe [$];   // keys_in history not yet visible at the synchroniser output
  logic [3:0] win  [$];   // last D synchronised samples seen by the debouncer
  logic [3:0] m_stable, m_pulse, m_cap;

  key_debounce_irq #(
    .WIDTH(4), .DEBOUNCE_CYCLES(D), .CNT_W(20), .ACTIVE_LOW(1), .EDGE_MODE(2)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .keys_raw(keys_raw),
    .keys_stable(keys_stable), .edge_pulse(edge_pulse), .edge_capture(edge_capture),
    .capture_clear(capture_clear), .irq_mask(irq_mask), .irq(irq)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp_v);
    end
  endtask

  // A bit is accepted once D consecutive synchronised samples all differ
  // from the accepted level; the synchroniser is a plain 2-sample delay.
  task automatic tick();
    logic [3:0] x, s2, nxt;
    logic ok;
    x = ~keys_raw;
    if (reset_reset) begin
      pipe = '{4'h0, 4'h0};
      win.delete();
      m_stable = '0; m_pulse = '0; m_cap = '0;
    end else begin
      s2 = pipe.pop_front();
      pipe.push_back(x);
      win.push_back(s2);
      if (win.size() > D) void'(win.pop_front());
      nxt = m_stable;
      for (int i = 0; i < 4; i++) begin
        ok = (win.size() == D);
        foreach (win[j]) if (win[j][i] == m_stable[i]) ok = 1'b0;
        if (ok) nxt[i] = ~m_stable[i];
      end
      m_cap    = (m_cap & ~capture_clear) | m_pulse;
      m_pulse  = nxt ^ m_stable;
      m_stable = nxt;
    end
    @(posedge clk_clk);
    #1;
    chk("stable",  keys_stable,  m_stable);
    chk("pulse",   edge_pulse,   m_pulse);
    chk("capture", edge_capture, m_cap);
    chk("irq",     irq,          |(m_cap & irq_mask));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int lat;
    reset_reset = 1'b1; keys_raw = 4'hF; capture_clear = '0; irq_mask = 4'hF;

    // 1: idle after reset
    ticks(3);
    reset_reset = 1'b0;
    ticks(50);
    chk("idle_stable", keys_stable, 4'h0);

    // 2: clean press of key 0, latency D+2
    keys_raw[0] = 1'b0;
    lat = 0;
    for (int k = 0; k < 30 && !keys_stable[0]; k++) begin tick(); lat++; end
    chk("lat_key0", lat, D + 2);
    ticks(3);

    // 3: key 1 bounces every 3 cycles, then settles pressed
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) keys_raw[1] = ~keys_raw[1];
      tick();
      chk("bounce_hold", keys_stable[1], 1'b0);
    end
    keys_raw[1] = 1'b0;
    ticks(15);
    chk("bounce_accept", keys_stable[1], 1'b1);

    // 4: masked capture, unmask, clear
    irq_mask = 4'h0;
    keys_raw[2] = 1'b0; ticks(15);
    keys_raw[2] = 1'b1; ticks(15);
    chk("masked_cap2", edge_capture[2], 1'b1);
    chk("masked_irq", irq, 1'b0);
    irq_mask = 4'h4; #1;
    chk("unmask_irq", irq, 1'b1);
    capture_clear = 4'h4; tick();
    capture_clear = 4'h0; tick();
    chk("clear_irq", irq, 1'b0);

    // 5: clear coinciding with an accepted key-3 edge
    capture_clear = 4'h8; tick(); capture_clear = 4'h0;
    keys_raw[3] = 1'b0;
    ticks(D + 2);
    chk("edge3_pulse", edge_pulse[3], 1'b1);
    capture_clear = 4'h8; tick(); capture_clear = 4'h0;
    chk("set_wins", edge_capture[3], 1'b1);

    // 6: reset while key 0 is mid-count and key 1 is held
    keys_raw = 4'hF; ticks(15);
    keys_raw = 4'hD; ticks(15);
    chk("pre_rst_stable", keys_stable, 4'h2);
    keys_raw = 4'hC; ticks(7);
    reset_reset = 1'b1; tick();
    chk("rst_stable", keys_stable, 4'h0);
    chk("rst_pulse", edge_pulse, 4'h0);
    reset_reset = 1'b0;
    ticks(15);
    chk("reaccept", keys_stable, 4'h3);

    // random activity
    irq_mask = 4'hF;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(11) == 0) keys_raw[i] = ~keys_raw[i];
        capture_clear[i] = ($urandom_range(15) == 0);
      end
      reset_reset = ($urandom_range(599) == 0);
      tick();
      if ($urandom_range(31) == 0) begin
        irq_mask = 4'($urandom_range(15));
        #1;
        chk("mask_irq", irq, |(m_cap & irq_mask));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
